counter_checker: RTL
====================

Name: counter_checker

Overview:
- Downstream monitor that consumes the `count` bus of the `counter` block on the same clock.
- Checks that `count` advances by exactly +1 (mod 2^Size) every clock edge. Counts wrap-arounds and sequence errors, and raises a sticky fault.
- Emits a one-cycle match pulse when `count` equals a programmable value.
- Instantiated beside `counter` in bench top levels, so the Ruby side can read health status instead of reconstructing the sequence itself.

Parameters:
- Size, 5, width of the observed `count` bus; must equal the counter's Size.
- WrapWidth, 8, width of the `wraps` counter.
- ErrWidth, 8, width of the `errors` counter.

Ports:
- clock  input  1  rising-edge clock, same clock as the counter.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- count  input  Size  counter value, sampled at each rising edge of `clock`.
- clear  input  1  synchronous clear of status and statistics.
- match_value  input  Size  compare value for `match`.
- synced  output  1  1 once a reference sample has been taken.
- wraps  output  WrapWidth  number of wrap-arounds seen; saturates at all-ones.
- errors  output  ErrWidth  number of sequence errors seen; saturates at all-ones.
- fault  output  1  sticky error flag.
- match  output  1  one-cycle pulse when sampled `count` == `match_value`.

Behaviour:
- Reset (reset=0, asynchronous, independent of clock):
  - state=SYNC; internal `prev`=0.
  - synced=0, wraps=0, errors=0, fault=0, match=0.
  - Outputs go to these values immediately, without waiting for a clock edge.
- Latency: every output is registered. An output reflects the `count` sampled at edge N starting just after edge N.
- States: SYNC, TRACK, FAULT.
  - SYNC: on the first edge, prev←count, no check is made, go to TRACK, synced←1.
  - TRACK/FAULT: expected = (prev+1) mod 2^Size. Each edge evaluates in this order:
    - count==expected: legal. If prev==all-ones (so count==0), wraps increments, saturating.
    - count==0 and not expected: legal upstream restart (the counter's synchronous reset). No error, no wrap increment.
    - Any other value: errors increments (saturating), fault←1, state←FAULT.
    - prev←count on every edge in both states.
  - FAULT: behaves exactly like TRACK; further errors keep incrementing `errors`. It leaves FAULT only via `clear` or `reset`.
- Holding `count` at 0 for several edges is legal: each 0 after a 0 is a restart, not an error.
- match: asserted for exactly one cycle after each edge where sampled count==match_value, in all states including SYNC. If the value is held, match stays high for each consecutive edge.
- clear=1 at an edge:
  - state←SYNC; synced, wraps, errors, fault, match←0.
  - `clear` has priority over any check or match result at that same edge.
- Arithmetic:
  - `expected` is computed Size bits wide and wraps naturally.
  - Counters hold at all-ones and never roll over to 0.
- `match_value` change takes effect at the next edge; no internal staging.

Test Plan:
1. Release reset, drive count 0,1,…,31,0,1 on successive edges → after the edge sampling the second 0: wraps=1, errors=0, fault=0, synced=1.
2. Drive 3,4,5 then 7,8,9 (skip 6) → after the edge sampling 7: errors=1, fault=1. After 8 and 9: errors still 1, fault still 1.
3. Mid-run restart: sequence 10,11,12,0,0,0,1,2 → errors=0, fault=0, wraps unchanged.
4. match_value=7, free-running 0..31 for 64 edges → match high for exactly 2 single cycles, each directly after the edge that sampled 7.
5. WrapWidth=2, free run through 5 full wraps → wraps reads 1,2,3,3,3. With ErrWidth=2 and 5 injected skips → errors saturates at 3.
6. Assert reset=0 between clock edges mid-run → all outputs 0 without a clock edge. Then apply clear=1 on an edge carrying a skip → errors=0, fault=0, synced=0 after that edge.

Source files
------------

// File: rtl/counter_checker.sv
// Sequence monitor for the counter's count bus: checks +1 steps, tallies wraps and
// sequence errors, holds a sticky fault and pulses match on a programmable value.
module counter_checker #(
    parameter int unsigned Size      = 5,
    parameter int unsigned WrapWidth = 8,
    parameter int unsigned ErrWidth  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [Size-1:0]      count,
    input  logic                 clear,
    input  logic [Size-1:0]      match_value,
    output logic                 synced,
    output logic [WrapWidth-1:0] wraps,
    output logic [ErrWidth-1:0]  errors,
    output logic                 fault,
    output logic                 match
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [Size-1:0]      prev_p0, prev_nxt;
    logic                 synced_p0, synced_nxt;
    logic [WrapWidth-1:0] wraps_p0, wraps_nxt;
    logic [ErrWidth-1:0]  errors_p0, errors_nxt;
    logic                 fault_p0, fault_nxt;
    logic                 match_p0, match_nxt;
    logic [Size-1:0]      expected;

    function automatic logic [WrapWidth-1:0] sat_inc_wrap(input logic [WrapWidth-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [ErrWidth-1:0] sat_inc_err(input logic [ErrWidth-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Successor wraps naturally because it is held to Size bits.
    assign expected = prev_p0 + 1'b1;

    always_comb begin
        state_nxt  = state;
        prev_nxt   = count;
        synced_nxt = synced_p0;
        wraps_nxt  = wraps_p0;
        errors_nxt = errors_p0;
        fault_nxt  = fault_p0;
        match_nxt  = (count == match_value);

        if (clear) begin
            state_nxt  = SYNC;
            synced_nxt = 1'b0;
            wraps_nxt  = '0;
            errors_nxt = '0;
            fault_nxt  = 1'b0;
            match_nxt  = 1'b0;
        end else begin
            case (state)
                SYNC: begin
                    state_nxt  = TRACK;
                    synced_nxt = 1'b1;
                end
                TRACK, FAULT: begin
                    if (count == expected) begin
                        if (&prev_p0)
                            wraps_nxt = sat_inc_wrap(wraps_p0);
                    end else if (count != '0) begin
                        // A zero that is not the successor is an upstream restart, not an error.
                        errors_nxt = sat_inc_err(errors_p0);
                        fault_nxt  = 1'b1;
                        state_nxt  = FAULT;
                    end
                end
                default: begin
                    state_nxt = SYNC;
                end
            endcase
        end
    end

    // Stage p0: every output is registered from the sample taken at this edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= SYNC;
            prev_p0   <= '0;
            synced_p0 <= 1'b0;
            wraps_p0  <= '0;
            errors_p0 <= '0;
            fault_p0  <= 1'b0;
            match_p0  <= 1'b0;
        end else begin
            state     <= state_nxt;
            prev_p0   <= prev_nxt;
            synced_p0 <= synced_nxt;
            wraps_p0  <= wraps_nxt;
            errors_p0 <= errors_nxt;
            fault_p0  <= fault_nxt;
            match_p0  <= match_nxt;
        end
    end

    assign synced = synced_p0;
    assign wraps  = wraps_p0;
    assign errors = errors_p0;
    assign fault  = fault_p0;
    assign match  = match_p0;

endmodule
